// File: rtl/voltage_bcd_converter_if.sv
// Port bundle between the ADC/displayer side (master) and the millivolt BCD converter (slave).
// fsm_state mirrors the converter's state register for observation.
interface voltage_bcd_converter_if #(
  parameter int ADC_WIDTH = 12,
  parameter int MV_WIDTH  = 14
);
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 flag;
  logic                 busy;
  logic                 valid;
  logic                 overrun;
  logic                 clamped;
  logic [MV_WIDTH-1:0]  mv_value;
  logic [15:0]          bcd_digits;
  logic [1:0]           fsm_state;

  // Handshake: flag is a one-cycle request taken only while the converter is IDLE;
  // busy covers every cycle from the one after acceptance up to and including the
  // valid cycle; valid is a one-cycle pulse and the result outputs change only with it.
  modport master (
    output adc_data, flag,
    input  busy, valid, overrun, clamped, mv_value, bcd_digits, fsm_state
  );

  modport slave (
    input  adc_data, flag,
    output busy, valid, overrun, clamped, mv_value, bcd_digits, fsm_state
  );
endinterface

// File: rtl/voltage_bcd_converter.sv
// ADC code -> clamped millivolts -> packed BCD via a sequential double-dabble engine.
// Define VOLT_AVG_EN to average 2^AVG_LOG2 accepted samples before each conversion.
module voltage_bcd_converter #(
  parameter int ADC_WIDTH   = 12,
  parameter int VREF_MV     = 5000,
  parameter int CLAMP_CODE  = 2000,
  parameter int SCALE_SHIFT = 11,
  parameter int MV_WIDTH    = 14,
  parameter int AVG_LOG2    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  voltage_bcd_converter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PROD_W = ADC_WIDTH + 14;
  localparam int CNT_W  = $clog2(MV_WIDTH + 1);

  localparam logic [13:0]          VREF_C    = 14'(VREF_MV);
  localparam logic [MV_WIDTH-1:0]  VREF_MV_C = MV_WIDTH'(VREF_MV);
  localparam logic [ADC_WIDTH-1:0] CLAMP_C   = ADC_WIDTH'(CLAMP_CODE);
  localparam logic [CNT_W-1:0]     CNT_INIT  = CNT_W'(MV_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(1);

  state_t               state;
  state_t               state_next;

  logic [ADC_WIDTH-1:0] code_q;
  logic [MV_WIDTH-1:0]  bin_q;
  logic [MV_WIDTH-1:0]  mv_hold_q;
  logic [15:0]          bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 clamp_pend_q;

  logic [MV_WIDTH-1:0]  mv_out_q;
  logic [15:0]          bcd_out_q;
  logic                 clamped_q;
  logic                 overrun_q;

  logic                 accept;
  logic                 start_conv;
  logic [ADC_WIDTH-1:0] start_code;

  assign accept = bus.flag && (state == IDLE);

`ifdef VOLT_AVG_EN
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] smp_q;
  logic [ACC_W-1:0]    acc_sum;
  logic                last_smp;

  assign acc_sum    = acc_q + ACC_W'(bus.adc_data);
  assign last_smp   = (smp_q == '1);
  assign start_conv = accept && last_smp;
  // Clamping later acts on this averaged code, never on individual samples.
  assign start_code = ADC_WIDTH'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      smp_q <= '0;
    end else if (accept) begin
      if (last_smp) begin
        acc_q <= '0;
        smp_q <= '0;
      end else begin
        acc_q <= acc_sum;
        smp_q <= smp_q + 1'b1;
      end
    end
  end
`else
  assign start_conv = accept;
  assign start_code = bus.adc_data;
`endif

  // Scaling: full-width product so no bits are lost before the final shift.
  logic [PROD_W-1:0]   prod;
  logic [MV_WIDTH-1:0] mv_scaled;
  logic                over;
  logic [MV_WIDTH-1:0] mv_calc;

  assign prod      = PROD_W'(code_q) * PROD_W'(VREF_C);
  assign mv_scaled = MV_WIDTH'(prod >> SCALE_SHIFT);
  assign over      = (code_q > CLAMP_C);
  assign mv_calc   = over ? VREF_MV_C : mv_scaled;

  // One double-dabble step: add-3 correction on every nibble, then shift in the next bit.
  logic [15:0]         bcd_adj;
  logic [15:0]         bcd_shift;
  logic [MV_WIDTH-1:0] bin_shift;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], bin_q[MV_WIDTH-1]};
    bin_shift = {bin_q[MV_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_conv) state_next = SCALE;
      SCALE:   state_next = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q       <= '0;
      bin_q        <= '0;
      mv_hold_q    <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      clamp_pend_q <= 1'b0;
      mv_out_q     <= '0;
      bcd_out_q    <= '0;
      clamped_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (bus.flag && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_conv) code_q <= start_code;
        end
        SCALE: begin
          bin_q        <= mv_calc;
          mv_hold_q    <= mv_calc;
          bcd_q        <= '0;
          cnt_q        <= CNT_INIT;
          clamp_pend_q <= over;
        end
        SHIFT: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q - 1'b1;
          // Results land on the last shift so they are visible throughout the DONE/valid cycle.
          if (cnt_q == CNT_LAST) begin
            bcd_out_q <= bcd_shift;
            mv_out_q  <= mv_hold_q;
            clamped_q <= clamp_pend_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.valid      = (state == DONE);
  assign bus.overrun    = overrun_q;
  assign bus.clamped    = clamped_q;
  assign bus.mv_value   = mv_out_q;
  assign bus.bcd_digits = bcd_out_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_voltage_bcd_converter.sv
// Directed bench for voltage_bcd_converter: reset state, conversions, overrun, mid-run reset,
// and the averaging path when VOLT_AVG_EN is defined.
module tb_voltage_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  voltage_bcd_converter_if #(.ADC_WIDTH(12), .MV_WIDTH(14)) bus ();

  voltage_bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.flag = 1'b0;
    bus.adc_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Flag one code, wait (bounded) for valid, then check latency, results and hold.
  task automatic run_conv(input string tag, input logic [11:0] code, input logic [13:0] exp_mv,
                          input logic [15:0] exp_bcd, input logic exp_clamp);
    int n;
    n = 0;
    tick();
    bus.adc_data = code;
    bus.flag = 1'b1;
    while (n < 40) begin
      tick();
      bus.flag = 1'b0;
      n++;
      if (bus.valid) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_mv"}, 32'(bus.mv_value), 32'(exp_mv));
    check({tag, "_bcd"}, 32'(bus.bcd_digits), 32'(exp_bcd));
    check({tag, "_clamped"}, 32'(bus.clamped), 32'(exp_clamp));
    check({tag, "_busy_at_valid"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, "_valid_pulse"}, 32'(bus.valid), 32'd0);
    check({tag, "_mv_hold"}, 32'(bus.mv_value), 32'(exp_mv));
  endtask

  int   valid_cnt;
  int   first_cyc;
  int   second_cyc;
  logic [13:0] first_mv;
  logic [13:0] second_mv;
  logic        busy_c5;

  initial begin
    bus.flag = 1'b0;
    bus.adc_data = '0;
    do_reset();

    check("rst_busy",    32'(bus.busy),       32'd0);
    check("rst_valid",   32'(bus.valid),      32'd0);
    check("rst_overrun", 32'(bus.overrun),    32'd0);
    check("rst_clamped", 32'(bus.clamped),    32'd0);
    check("rst_mv",      32'(bus.mv_value),   32'd0);
    check("rst_bcd",     32'(bus.bcd_digits), 32'd0);

`ifdef VOLT_AVG_EN
    // Three non-final samples must not start a conversion.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.adc_data = (i == 2) ? 12'd2000 : 12'd1000;
      bus.flag = 1'b1;
      tick();
      bus.flag = 1'b0;
      check("avg_partial_busy",  32'(bus.busy),  32'd0);
      check("avg_partial_valid", 32'(bus.valid), 32'd0);
    end
    run_conv("avg", 12'd2000, 14'd3662, 16'h3662, 1'b0);
`else
    run_conv("c1024", 12'd1024, 14'd2500, 16'h2500, 1'b0);
    run_conv("c2000", 12'd2000, 14'd4882, 16'h4882, 1'b0);
    run_conv("c2001", 12'd2001, 14'd5000, 16'h5000, 1'b1);
    run_conv("c4095", 12'd4095, 14'd5000, 16'h5000, 1'b1);
    run_conv("c0",    12'd0,    14'd0,    16'h0000, 1'b0);
    run_conv("c1",    12'd1,    14'd2,    16'h0002, 1'b0);

    // Overrun: second flag at cycle 5 ignored; flag at cycle 17 starts a new conversion.
    do_reset();
    valid_cnt = 0; first_cyc = -1; second_cyc = -1;
    first_mv = '0; second_mv = '0; busy_c5 = 1'b0;
    tick();
    bus.adc_data = 12'd1024;
    bus.flag = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      bus.flag = 1'b0;
      if (bus.valid) begin
        valid_cnt++;
        if (first_cyc < 0) begin
          first_cyc = c;
          first_mv  = bus.mv_value;
        end else begin
          second_cyc = c;
          second_mv  = bus.mv_value;
        end
      end
      if (c == 5) begin
        busy_c5 = bus.busy;
        bus.adc_data = 12'd4095;
        bus.flag = 1'b1;
      end
      if (c == 17) begin
        bus.adc_data = 12'd1;
        bus.flag = 1'b1;
      end
    end
    check("ovr_busy_c5",     32'(busy_c5),    32'd1);
    check("ovr_valid_count", 32'(valid_cnt),  32'd2);
    check("ovr_first_cyc",   32'(first_cyc),  32'd16);
    check("ovr_first_mv",    32'(first_mv),   32'd2500);
    check("ovr_second_cyc",  32'(second_cyc), 32'd33);
    check("ovr_second_mv",   32'(second_mv),  32'd2);
    check("ovr_sticky",      32'(bus.overrun), 32'd1);

    // Mid-conversion reset after a clamped result so the clears are visible.
    run_conv("pre_rst", 12'd4095, 14'd5000, 16'h5000, 1'b1);
    tick();
    bus.adc_data = 12'd1024;
    bus.flag = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.flag = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy",    32'(bus.busy),       32'd0);
    check("mrst_valid",   32'(bus.valid),      32'd0);
    check("mrst_overrun", 32'(bus.overrun),    32'd0);
    check("mrst_clamped", 32'(bus.clamped),    32'd0);
    check("mrst_mv",      32'(bus.mv_value),   32'd0);
    check("mrst_bcd",     32'(bus.bcd_digits), 32'd0);
    valid_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.valid) valid_cnt++;
    end
    check("mrst_no_valid", 32'(valid_cnt), 32'd0);
    run_conv("post_rst", 12'd1024, 14'd2500, 16'h2500, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voltage_bcd_converter.md
Name: voltage_bcd_converter

Overview:
Parametrised successor to the single-cycle ADC-to-7-segment voltage calculator. Captures an ADC code on each update flag, scales and clamps it to millivolts, then converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. Sits between the ADC register and the 7-segment displayer. A start/busy/valid handshake replaces the free-running update.

Parameters:
ADC_WIDTH, 12, ADC code width in bits.
VREF_MV, 5000, full-scale millivolts; the clamp output value; must be ≤ 9999.
CLAMP_CODE, 2000, codes strictly above this clamp to VREF_MV.
SCALE_SHIFT, 11, mV = (code*VREF_MV) >> SCALE_SHIFT.
MV_WIDTH, 14, millivolt register width; 2^MV_WIDTH must be > VREF_MV.
AVG_LOG2, 2, log2 of the averaging depth; used only with VOLT_AVG_EN.

Ports:
clk  in  1  system clock (12 MHz)
rst  in  1  synchronous, active-high reset
adc_data  in  ADC_WIDTH  ADC code, sampled on the cycle flag is accepted
flag  in  1  update request, one-cycle pulse from the displayer
busy  out  1  high from the cycle after acceptance until the cycle valid is high, inclusive
valid  out  1  one-cycle pulse; bcd_digits and mv_value updated the same cycle
overrun  out  1  sticky; set when flag arrives while not IDLE; cleared only by rst
clamped  out  1  high when the latest result was clamped; updated with valid
mv_value  out  MV_WIDTH  latest millivolt value
bcd_digits  out  16  four BCD digits: [15:12] volts, [11:8] tenths, [7:4] hundredths, [3:0] thousandths

Behaviour:
- Reset: state IDLE; busy=0, valid=0, overrun=0, clamped=0, mv_value=0, bcd_digits=0; averaging accumulator and sample counter = 0.
- States are IDLE, SCALE, SHIFT and DONE.
- IDLE: when flag=1, register adc_data and go to SCALE. Otherwise stay.
- SCALE, one cycle:
  - If code > CLAMP_CODE, mv = VREF_MV and the pending clamp bit = 1.
  - Else mv = (code*VREF_MV) >> SCALE_SHIFT, truncating, and the pending clamp bit = 0.
  - The product is formed at ADC_WIDTH+14 bits with no intermediate truncation.
  - Load the shift register with mv, clear the BCD scratch, set iteration count = MV_WIDTH, then go to SHIFT.
- SHIFT, MV_WIDTH cycles. Each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Then shift {bcd, bin} left by 1 and decrement the count.
  - Leave for DONE when the count reaches 0.
- DONE, one cycle: drive valid=1, load bcd_digits, mv_value and clamped, then return to IDLE.
- Latency: a flag accepted in cycle N gives valid in cycle N+MV_WIDTH+2. With the defaults this is N+16.
- Outputs hold their values between valid pulses.
- A flag while busy, or in the DONE cycle, is ignored and sets overrun. The in-flight conversion is not disturbed.
- A flag in the IDLE cycle directly after DONE is accepted normally, so back-to-back conversions are possible.
- rst asserted mid-conversion: next cycle returns to the reset state. No valid is produced and the outputs go to 0.
- The BCD result never exceeds 9999 given the VREF_MV constraint, so no digit-overflow handling is required.

Optional Feature:
VOLT_AVG_EN.
- Defined:
  - Each accepted flag adds adc_data to an (ADC_WIDTH+AVG_LOG2)-bit accumulator and increments the sample counter.
  - On the 2^AVG_LOG2-th sample, the code passed to SCALE is accumulator >> AVG_LOG2, truncated. The accumulator and counter then clear.
  - On non-final samples the block stays in IDLE with busy=0 and valid=0.
  - Clamping is applied to the averaged code, not to the individual samples.
  - rst clears the accumulator and the counter.
- Not defined: every accepted flag converts its own sample, and no accumulator is synthesised.

Test Plan:
- Reset, then adc_data=1024, flag pulse → valid exactly 16 cycles later; mv_value=2500, bcd_digits=16'h2500, clamped=0.
- adc_data=2000 → mv_value=4882, bcd_digits=16'h4882, clamped=0. adc_data=2001 → mv_value=5000, 16'h5000, clamped=1. adc_data=4095 → 16'h5000, clamped=1.
- adc_data=0 → 16'h0000. adc_data=1 → mv_value=2, bcd_digits=16'h0002. Checks truncation and that digit add-3 does not fire spuriously.
- flag at cycle 0, then flag again at cycle 5 → one valid at cycle 16, overrun=1 and stays 1. A flag at cycle 17 is accepted, with valid at cycle 33.
- rst pulsed at cycle 8 of a conversion → no valid, all outputs 0, busy=0. A new flag then converts correctly.
- VOLT_AVG_EN with AVG_LOG2=2, codes 1000, 1000, 2000, 2000 on four flags → one valid only, 16 cycles after the 4th flag; mv_value=3662, bcd_digits=16'h3662.
